// File: rtl/adder_operand_loader.sv
// Sequential front-end for the 8-bit CLA/KSA adder: loads A then B from one byte stream,
// holds them for a settle window, then offers the captured sum/carry on a result stream.
module adder_operand_loader #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    input  logic [7:0]         add_sum,
    input  logic               add_cout,
    output logic [7:0]         res_sum,
    output logic               res_cout,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t               r_state;
    logic [3:0]           r_settle_cnt;
    logic [7:0]           r_add_a;
    logic [7:0]           r_add_b;
    logic [7:0]           r_res_sum;
    logic                 r_res_cout;
    logic                 r_res_valid;
    logic [COUNT_W-1:0]   r_op_count;
    logic                 w_loading;

    assign w_loading = (r_state == LOAD_A) || (r_state == LOAD_B);
    // rst_n gates in_ready so the producer sees no acceptance while reset is held
    assign in_ready  = rst_n & ena & w_loading;
    assign busy      = (r_state == SETTLE) || (r_state == HOLD);

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_valid = r_res_valid;
    assign op_count  = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD_A;
            r_settle_cnt <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_res_sum    <= '0;
            r_res_cout   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_op_count   <= '0;
        end else if (ena) begin
            case (r_state)
                LOAD_A: begin
                    if (in_valid) begin
                        r_add_a <= in_data;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        r_add_b      <= in_data;
                        r_settle_cnt <= SETTLE_INIT;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_res_sum   <= add_sum;
                        r_res_cout  <= add_cout;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + COUNT_W'(1);
                        r_state     <= LOAD_A;
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Bench for adder_operand_loader: two instances (settle 1 and 4) driven with directed and
// $urandom operand pairs, checked against a plain-arithmetic model of the result stream.
module tb_adder_operand_loader;

    localparam int unsigned S0 = 1;
    localparam int unsigned S1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [2];
    logic       ena       [2];
    logic [7:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] add_a     [2];
    logic [7:0] add_b     [2];
    logic [7:0] add_sum   [2];
    logic       add_cout  [2];
    logic [7:0] res_sum   [2];
    logic       res_cout  [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic       busy      [2];
    logic [7:0] op_count  [2];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned exp_count [2];
    int unsigned settle_of [2];

    // Combinational adder seen by each instance, carry-in tied to 0
    assign {add_cout[0], add_sum[0]} = 9'(add_a[0]) + 9'(add_b[0]);
    assign {add_cout[1], add_sum[1]} = 9'(add_a[1]) + 9'(add_b[1]);

    adder_operand_loader #(.SETTLE_CYCLES(S0), .COUNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .ena(ena[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]), .add_cout(add_cout[0]),
        .res_sum(res_sum[0]), .res_cout(res_cout[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    adder_operand_loader #(.SETTLE_CYCLES(S1), .COUNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .ena(ena[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]), .add_cout(add_cout[1]),
        .res_sum(res_sum[1]), .res_cout(res_cout[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] data);
        int unsigned t;
        repeat ($urandom_range(0, 1)) step();
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        t = 0;
        while (in_ready[d] !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        check("in_ready_wait", 32'(in_ready[d]), 32'd1);
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic load_pair(input int d, input logic [7:0] a, input logic [7:0] b);
        send_byte(d, a);
        check("add_a_load", 32'(add_a[d]), 32'(a));
        check("busy_loadb", 32'(busy[d]), 32'd0);
        send_byte(d, b);
        check("add_b_load", 32'(add_b[d]), 32'(b));
        check("add_a_keep", 32'(add_a[d]), 32'(a));
        check("in_ready_settle", 32'(in_ready[d]), 32'd0);
    endtask

    // Edges after the B transfer edge until res_valid: SETTLE_CYCLES plus any disabled cycles
    task automatic wait_result(input int d, input logic [7:0] a, input logic [7:0] b,
                               input int unsigned drop_k);
        int unsigned edges;
        logic [8:0]  full;
        full  = 9'(a) + 9'(b);
        edges = 0;
        if (drop_k > 0) begin
            ena[d] = 1'b0;
            check("in_ready_ena_low", 32'(in_ready[d]), 32'd0);
            repeat (drop_k) begin
                step();
                edges++;
            end
            check("res_valid_frozen", 32'(res_valid[d]), 32'd0);
            ena[d] = 1'b1;
        end
        while (res_valid[d] !== 1'b1 && edges < 60) begin
            step();
            edges++;
        end
        check("latency", edges, settle_of[d] + drop_k);
        check("res_sum", 32'(res_sum[d]), 32'(full[7:0]));
        check("res_cout", 32'(res_cout[d]), 32'(full[8]));
        check("busy_hold", 32'(busy[d]), 32'd1);
    endtask

    task automatic accept(input int d, input logic [7:0] a, input logic [7:0] b,
                          input int unsigned hold);
        logic [8:0] full;
        full = 9'(a) + 9'(b);
        res_ready[d] = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 8'($urandom);
            step();
            check("bp_valid", 32'(res_valid[d]), 32'd1);
            check("bp_sum", 32'({res_cout[d], res_sum[d]}), 32'(full));
            check("bp_in_ready", 32'(in_ready[d]), 32'd0);
        end
        in_valid[d]  = 1'b0;
        res_ready[d] = 1'b1;
        step();
        res_ready[d] = 1'b0;
        exp_count[d] = (exp_count[d] + 1) % 256;
        check("valid_drop", 32'(res_valid[d]), 32'd0);
        check("op_count", 32'(op_count[d]), exp_count[d]);
        check("add_a_ignored", 32'(add_a[d]), 32'(a));
        check("in_ready_idle", 32'(in_ready[d]), 32'd1);
    endtask

    task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input int unsigned drop_k, input int unsigned hold);
        load_pair(d, a, b);
        wait_result(d, a, b, drop_k);
        accept(d, a, b, hold);
    endtask

    task automatic async_reset(input int d);
        #3;
        rst_n[d] = 1'b0;
        #1;
        check("rst_add_a", 32'(add_a[d]), 32'd0);
        check("rst_add_b", 32'(add_b[d]), 32'd0);
        check("rst_res", 32'({res_valid[d], res_cout[d], res_sum[d]}), 32'd0);
        check("rst_count", 32'(op_count[d]), 32'd0);
        check("rst_in_ready", 32'(in_ready[d]), 32'd0);
        check("rst_busy", 32'(busy[d]), 32'd0);
        exp_count[d] = 0;
        #1;
        rst_n[d] = 1'b1;
        step();
        check("rst_load_a", 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        settle_of[0] = S0;
        settle_of[1] = S1;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            ena[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            res_ready[d] = 1'b0;
            exp_count[d] = 0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_in_ready", 32'(in_ready[d]), 32'd0);
            check("reset_outs", 32'({add_a[d], add_b[d], res_sum[d]}), 32'd0);
            check("reset_valid", 32'(res_valid[d]), 32'd0);
            check("reset_count", 32'(op_count[d]), 32'd0);
            rst_n[d] = 1'b1;
        end
        step();

        do_op(0, 8'h3C, 8'h5A, 0, 0);
        do_op(0, 8'hFF, 8'h01, 0, 0);
        do_op(0, 8'h80, 8'h80, 0, 0);
        do_op(0, 8'h00, 8'h00, 0, 0);
        do_op(0, 8'($urandom), 8'($urandom), 0, 5);

        do_op(1, 8'($urandom), 8'($urandom), 0, 0);
        do_op(1, 8'($urandom), 8'($urandom), 3, 0);

        load_pair(1, 8'h12, 8'h34);
        step();
        check("in_settle", 32'(busy[1]), 32'd1);
        async_reset(1);
        do_op(1, 8'hA5, 8'h5B, 0, 1);

        load_pair(1, 8'h77, 8'h99);
        wait_result(1, 8'h77, 8'h99, 0);
        async_reset(1);
        do_op(1, 8'h01, 8'hFE, 0, 0);

        repeat (40) do_op(1, 8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        repeat (20) do_op(0, 8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));

        async_reset(0);
        for (int i = 0; i < 256; i++)
            do_op(0, 8'($urandom), 8'($urandom), 0, $urandom_range(0, 1));
        check("count_wrap", 32'(op_count[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
